// File: rtl/dmem_responder.sv
// Purpose : memory end of the CPU data bus; request/ready handshake in front of a word RAM with byte-lane writes.
// Latency : request accepted at edge N, ready high for the single cycle after edge N+LATENCY (issue interval LATENCY+2).
// Backpr. : ready is the only completion signal; req is ignored while busy, so the CPU holds its request until ready.
//
// Ports: clk/rstn (sync active-low reset), req/we/addr/wdata/be (CPU request, held until ready),
//        rdata (registered read data, held between responses), ready (1-cycle response strobe),
//        busy (transaction in flight), err (out-of-range qualifier, valid with ready).
// Optional: define DM_RANGE_CHK_EN to flag addresses with nonzero bits above the array as errors
//           (err=1, rdata=0, no write); otherwise err is tied 0 and upper address bits alias.
module dmem_responder #(
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_V = 4'(LATENCY);
    localparam int         DEPTH = 1 << ADDR_W;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_idx;
    logic [31:0]         lat_wdata;
    logic [3:0]          lat_be;
    logic                lat_oor;
    logic [31:0]         mem [0:DEPTH-1];

    logic [ADDR_W-1:0]   in_idx;
    logic                in_oor;
    logic [ADDR_W-1:0]   rd_idx;
    logic                rd_oor;
    logic                unused_addr;

    assign in_idx = addr[ADDR_W+1:2];
`ifdef DM_RANGE_CHK_EN
    assign in_oor = |addr[31:ADDR_W+2];
`else
    assign in_oor = 1'b0;
`endif
    // Lane selection comes from be alone; without the range check the top bits alias.
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    // Next-state / counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_nxt   = LAT_V;
                    state_nxt = (LAT_V == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero latency RESP is entered straight from IDLE, before the request
    // has been latched, so the read index must come from the live inputs then.
    assign rd_idx = (state == S_IDLE) ? in_idx : lat_idx;
    assign rd_oor = (state == S_IDLE) ? in_oor : lat_oor;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            lat_oor   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && req) begin
                lat_we    <= we;
                lat_idx   <= in_idx;
                lat_wdata <= wdata;
                lat_be    <= be;
                lat_oor   <= in_oor;
            end
            // Capture the pre-write word on the edge entering RESP.
            if (state_nxt == S_RESP && state != S_RESP) begin
                rdata <= rd_oor ? 32'd0 : mem[rd_idx];
            end
        end
    end

    // RAM is never cleared; a write commits only on a clean exit from RESP,
    // so a reset asserted during RESP drops it.
    always_ff @(posedge clk) begin
        if (rstn && state == S_RESP && lat_we && !lat_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state == S_RESP);
    assign busy  = (state != S_IDLE);
`ifdef DM_RANGE_CHK_EN
    assign err   = (state == S_RESP) && lat_oor;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at latencies 1, 0, 5 and 4 share the
// request fields; each has its own req. A word-array model per instance predicts
// read data, error and write effects; handshake timing is predicted from LATENCY.
module tb_dmem_responder;

    logic        clk;
    logic        rstn;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  req;
    logic [31:0] rdata [4];
    logic [3:0]  ready;
    logic [3:0]  busy;
    logic [3:0]  err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [4][128];
    bit          known [4][128];

    dmem_responder #(.ADDR_W(7), .LATENCY(1)) u_l1 (
        .clk(clk), .rstn(rstn), .req(req[0]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]));
    dmem_responder #(.ADDR_W(7), .LATENCY(0)) u_l0 (
        .clk(clk), .rstn(rstn), .req(req[1]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]));
    dmem_responder #(.ADDR_W(7), .LATENCY(5)) u_l5 (
        .clk(clk), .rstn(rstn), .req(req[2]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .err(err[2]));
    dmem_responder #(.ADDR_W(7), .LATENCY(4)) u_l4 (
        .clk(clk), .rstn(rstn), .req(req[3]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata[3]), .ready(ready[3]), .busy(busy[3]), .err(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_oor(input logic [31:0] a);
`ifdef DM_RANGE_CHK_EN
        return (a[31:9] != 23'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one transaction on instance k; called with the clock low (#1 after an edge).
    // Ends #1 after the edge that leaves RESP, so a following call hits the minimum interval.
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd);
        int          lat;
        int          idx;
        bit          oor;
        bit          kn;
        logic [31:0] exp_rd;
        lat    = lat_of(k);
        idx    = int'(a[8:2]);
        oor    = model_oor(a);
        kn     = oor || known[k][idx];
        exp_rd = oor ? 32'd0 : mem_m[k][idx];
        we = w; addr = a; wdata = d; be = b; req[k] = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            chk("ready_timing", ready[k], (c == lat));
            chk("busy_inflight", busy[k], 1'b1);
            if (c < lat) begin
                chk("err_wait", err[k], 1'b0);
                // Request fields and req are ignored once accepted.
                req[k] = 1'($urandom);
                we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
            end
        end
        if (kn) chk("rdata_resp", rdata[k], exp_rd);
        chk("err_resp", err[k], oor);
        rd = rdata[k];
        req[k] = 1'($urandom);
        @(posedge clk); #1;
        chk("ready_width", ready[k], 1'b0);
        chk("busy_idle", busy[k], 1'b0);
        chk("rdata_hold", rdata[k], rd);
        req[k] = 1'b0;
        if (w && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) mem_m[k][idx][8*i +: 8] = d[8*i +: 8];
            end
            if (b == 4'hF) known[k][idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        rstn = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0; req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 128; i++) begin
                known[k][i] = 1'b0;
                mem_m[k][i] = 32'd0;
            end
        end

        // Reset held with req high: nothing accepted, outputs quiet.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                chk("rst_ready", ready[k], 1'b0);
                chk("rst_busy", busy[k], 1'b0);
                chk("rst_err", err[k], 1'b0);
                chk("rst_rdata", rdata[k], 32'd0);
            end
        end
        rstn = 1'b1;

        // First acceptance on the edge right after reset release, then clear every word.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 128; i++) begin
                txn(k, 1'b1, 32'(i * 4), 32'd0, 4'hF, rd);
            end
        end

        // Full-word write then read, latency 1.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
        chk("read_deadbeef", rd, 32'hDEADBEEF);
        // Byte-lane write: response carries the old word.
        txn(0, 1'b1, 32'h13, 32'h00AA0055, 4'b0101, rd);
        chk("wr_resp_old", rd, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
        chk("read_lanes", rd, 32'hDEAABE55);
        // be=0 write is a no-op.
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
        chk("read_be0", rd, 32'hDEAABE55);

        // Latency 0 and 5 with read-after-write.
        txn(1, 1'b1, 32'h44, 32'h12345678, 4'hF, rd);
        txn(1, 1'b0, 32'h44, 32'h0, 4'h0, rd);
        chk("l0_raw", rd, 32'h12345678);
        txn(2, 1'b1, 32'h7C, 32'hA5A5C3C3, 4'b1001, rd);
        txn(2, 1'b0, 32'h7C, 32'h0, 4'h0, rd);
        chk("l5_raw", rd, 32'hA50000C3);

        // Reset during WAIT drops the write.
        we = 1'b1; addr = 32'h20; wdata = 32'h11111111; be = 4'hF; req[3] = 1'b1;
        @(posedge clk); #1;
        req[3] = 1'b0;
        chk("mid_busy", busy[3], 1'b1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("mid_rst_busy", busy[3], 1'b0);
        chk("mid_rst_rdata", rdata[3], 32'd0);
        for (int c = 0; c < 6; c++) begin
            chk("mid_no_ready", ready[3], 1'b0);
            @(posedge clk); #1;
        end
        txn(3, 1'b0, 32'h20, 32'h0, 4'h0, rd);
        chk("mid_wait_nowrite", rd, 32'h0);

        // Reset during RESP drops the write.
        we = 1'b1; addr = 32'h30; wdata = 32'h77777777; be = 4'hF; req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        chk("resp_ready", ready[0], 1'b1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, rd);
        chk("mid_resp_nowrite", rd, 32'h0);

        // Out-of-range address: error with range check, aliasing to word 0 without.
        txn(0, 1'b1, 32'h00000400, 32'hCAFEF00D, 4'hF, rd);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
`ifdef DM_RANGE_CHK_EN
        chk("oor_word0", rd, 32'h0);
`else
        chk("alias_word0", rd, 32'hCAFEF00D);
`endif

        // Randomized traffic over a few words, with occasional upper-bit aliasing.
        for (int n = 0; n < 80; n++) begin
            int k;
            k = int'($urandom_range(0, 3));
            a = {(($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'd0), 7'($urandom_range(0, 7)), 2'($urandom)};
            txn(k, 1'($urandom), a, $urandom, 4'($urandom), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the CPU data-bus protocol.
- Replaces the single-cycle combinational data memory with a request/ready handshake, a programmable wait-state latency and byte-lane writes.
- Sits between the pipeline CPU's data port (Addr_out / Data_out / mem_w) and the word-addressed RAM array; the CPU stalls until ready.

Parameters:
- ADDR_W, 7, word-index width; array depth = 2**ADDR_W words (word index = addr[ADDR_W+1:2]).
- LATENCY, 1, wait states between request acceptance and the response cycle (0..15).

Ports:
- clk  input  1  CPU clock; all state on rising edge
- rstn  input  1  synchronous active-low reset
- req  input  1  CPU request valid; fields below held stable until ready
- we  input  1  1 = write, 0 = read
- addr  input  32  byte address from CPU
- wdata  input  32  write data
- be  input  4  byte enables; be[i] selects wdata[8i+7:8i]
- rdata  output  32  read data, registered
- ready  output  1  one-cycle response strobe
- busy  output  1  transaction in flight (state != IDLE)
- err  output  1  error response qualifier, valid with ready

Behaviour:
- Reset: synchronous; when rstn=0 at a clk edge: state=IDLE, ready=0, busy=0, err=0, rdata=0, wait counter=0. RAM contents are not cleared.
- States:
  - IDLE: if req=1, latch we/addr/wdata/be, load counter=LATENCY, go to WAIT if LATENCY>0, else go to RESP.
  - WAIT: decrement counter each cycle; when counter reaches 1, go to RESP. This gives exactly LATENCY cycles in WAIT.
  - RESP: ready=1 for exactly this cycle, then IDLE.
- Latency: request sampled in IDLE at edge N, ready high during cycle N+1+LATENCY.
- req is ignored in WAIT and RESP. A req still high during the RESP cycle is not accepted until the next IDLE cycle. Minimum issue interval is LATENCY+2 cycles.
- Read: rdata loaded with mem[index] at the edge entering RESP. rdata holds that value until the next response; it does not return to 0.
- Write:
  - Lanes with be[i]=1 are updated at the edge leaving RESP.
  - Lanes with be=0 are unchanged. be=4'b0000 is a legal no-op write.
  - rdata on a write response = the word before the write.
- The latched copy of the request is used throughout. Input changes after acceptance have no effect.
- Read-after-write to the same word in the next transaction returns the new data.
- addr[1:0] is ignored; lane selection comes from be only.
- Upper address bits [31:ADDR_W+2] are ignored (aliasing) unless DM_RANGE_CHK_EN is defined.
- Reset mid-transaction:
  - In WAIT: the transaction is dropped and no write is committed.
  - In RESP: the write is not committed.
- busy=1 in WAIT and RESP.

Optional Feature:
- Macro DM_RANGE_CHK_EN.
- Defined: at acceptance, any nonzero bit in addr[31:ADDR_W+2] marks the transaction out-of-range. At its RESP: err=1, rdata=0, no write committed. Latency is unchanged. err=0 on all other cycles.
- Undefined: err is tied 0 and upper address bits alias into the array.

Test Plan:
- Reset: hold rstn=0 3 cycles with req=1 -> ready=0, busy=0, err=0, rdata=0 throughout; first acceptance occurs the cycle after rstn=1.
- LATENCY=1: write addr 0x10, wdata 0xDEADBEEF, be=4'hF; then read 0x10 -> ready at accept+2 each time, read rdata=0xDEADBEEF, min interval 3 cycles.
- Byte lanes: after word 0x10=0xDEADBEEF, write wdata 0x00AA0055 with be=4'b0101 -> read 0x10 returns 0xDEAABE55; write response rdata=0xDEADBEEF.
- Latency sweep: LATENCY=0 and 5 -> ready exactly 1 and 6 cycles after accept; req wiggled during WAIT has no effect; ready width = 1 cycle.
- Reset mid-write: LATENCY=4, accept write 0x11111111 to 0x20 (old 0x0), pulse rstn=0 during WAIT -> ready never asserts; subsequent read of 0x20 returns 0x00000000.
- DM_RANGE_CHK_EN: write addr 0x00000400 (ADDR_W=7) -> err=1 with ready, rdata=0, word 0 unchanged; without macro the same write updates word 0 and err=0.
